// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multi-cycle RV32I core (shared instruction/data memory).
// Latency: Moore outputs valid in the same cycle as the state; 3 to 5 cycles per instruction.
// Backpressure: none; the FSM advances every clock, and rst abandons the current instruction.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   opcode, func3, func7         instruction fields from IR
//   zero, sign                   ALU flags (result == 0, result[31])
//   PCWrite, IRWrite, MemWrite, RegWrite    write enables, all forced low while rst is high
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc    datapath selects
//   illegal                      trap flag
//
// Build option: define ILLEGAL_TRAP_EN to make unknown opcodes enter a TRAP state.
// TRAP holds until reset and drives illegal=1. Without the macro, an unknown opcode
// returns to FETCH, which makes it a 2-cycle NOP, and illegal is tied low.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       sign,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_TGT = 4'd11,
        S_JALR_PC  = 4'd12,
        S_LUI      = 4'd13
`ifdef ILLEGAL_TRAP_EN
        ,
        S_TRAP     = 4'd14
`endif
    } state_t;

    state_t state, state_nxt;

    // Raw (ungated) enables; reset masks them at the ports.
    logic pcwrite_s, irwrite_s, memwrite_s, regwrite_s, illegal_s;

    // Only func7[5] selects SUB; the remaining bits are don't-care for RV32I ALU ops.
    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    // Shared R/I ALU decode. I-type passes sub=0 so "addi" never becomes a subtract.
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_dec = sub ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:    state_nxt = S_EXECR;
                    OP_I:    state_nxt = S_EXECI;
                    OP_LW,
                    OP_SW:   state_nxt = S_MEMADR;
                    OP_BR:   state_nxt = S_BRANCH;
                    OP_JAL:  state_nxt = S_JAL;
                    OP_JALR: state_nxt = S_JALR_TGT;
                    OP_LUI:  state_nxt = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default: state_nxt = S_TRAP;
`else
                    default: state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_nxt = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = S_FETCH;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_JALR_TGT: state_nxt = S_JALR_PC;
            S_JALR_PC:  state_nxt = S_ALUWB;
            S_LUI:      state_nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_nxt = S_TRAP;
`endif
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        pcwrite_s  = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        illegal_s  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_I;
        case (state)
            S_FETCH: begin
                // PC <= PC + 4 straight from the ALU result while IR is loaded.
                irwrite_s = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcwrite_s = 1'b1;
            end
            S_DECODE: begin
                // Speculatively form OldPC + imm for branch/jal targets.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_s = 1'b1;
                ImmSrc     = IMM_S;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(func3, func7[5]);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(func3, 1'b0);
            end
            S_ALUWB: regwrite_s = 1'b1;
            S_BRANCH: begin
                // Signed compare looks at the sign of rs1-rs2 only; overflow is ignored.
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                case (func3)
                    3'b000:  pcwrite_s = zero;
                    3'b001:  pcwrite_s = ~zero;
                    3'b100:  pcwrite_s = sign;
                    3'b101:  pcwrite_s = ~sign;
                    default: pcwrite_s = 1'b0;
                endcase
            end
            S_JAL, S_JALR_PC: begin
                // PC <= ALUOut (target) while the ALU computes OldPC + 4 for rd.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pcwrite_s = 1'b1;
            end
            S_JALR_TGT: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_LUI: begin
                ImmSrc     = IMM_U;
                ResultSrc  = 2'b11;
                regwrite_s = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: illegal_s = 1'b1;
`endif
            default: ;
        endcase
    end

    // Reset masks every write enable combinationally so nothing commits while rst is high.
    assign PCWrite  = pcwrite_s  & ~rst;
    assign IRWrite  = irwrite_s  & ~rst;
    assign MemWrite = memwrite_s & ~rst;
    assign RegWrite = regwrite_s & ~rst;
    assign illegal  = illegal_s  & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table of instructions with per-cycle expected outputs.
// Latency: one compare per clock, sampled on the falling edge.
// Backpressure: none; a watchdog bounds the run.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .zero(zero), .sign(sign), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, SLT = 3'b101, SLTU = 3'b110;
    localparam logic [2:0] IM_I = 3'b000, IM_S = 3'b001, IM_B = 3'b010, IM_J = 3'b011, IM_U = 3'b100;

    typedef struct packed {
        logic       pcw, irw, mw, rw, adr;
        logic [1:0] res, sa, sb;
        logic [2:0] alu, imm;
        logic       ill;
    } outv_t;

    typedef struct packed {
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic            z;
        logic            s;
        logic [2:0]      n;
        outv_t [4:0]     e;
    } vec_t;

    vec_t  tbl[$];
    outv_t scb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    outv_t act;

    always_comb act = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
                       ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

    function automatic outv_t ov(input logic pcw, input logic irw, input logic mw,
                                 input logic rw, input logic adr, input logic [1:0] res,
                                 input logic [1:0] sa, input logic [1:0] sb,
                                 input logic [2:0] alu, input logic [2:0] imm, input logic ill);
        ov = {pcw, irw, mw, rw, adr, res, sa, sb, alu, imm, ill};
    endfunction

    // Expected outputs per state.
    function automatic outv_t f_fetch(input logic en);
        f_fetch = ov(en, en, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD, IM_I, 0);
    endfunction
    function automatic outv_t f_decode(input logic j);
        f_decode = ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD, j ? IM_J : IM_B, 0);
    endfunction
    function automatic outv_t f_memadr(input logic s);
        f_memadr = ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, s ? IM_S : IM_I, 0);
    endfunction
    function automatic outv_t f_execr(input logic [2:0] a);
        f_execr = ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, a, IM_I, 0);
    endfunction
    function automatic outv_t f_execi(input logic [2:0] a);
        f_execi = ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, a, IM_I, 0);
    endfunction
    function automatic outv_t f_branch(input logic p);
        f_branch = ov(p, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, SUB, IM_I, 0);
    endfunction

    outv_t MEMREAD, MEMWB, MEMWRITE, ALUWB, JAL, JTGT, LUI, TRAP, Z;
    initial begin
        MEMREAD  = ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, IM_I, 0);
        MEMWB    = ov(0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, ADD, IM_I, 0);
        MEMWRITE = ov(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, ADD, IM_S, 0);
        ALUWB    = ov(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, ADD, IM_I, 0);
        JAL      = ov(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, ADD, IM_I, 0);
        JTGT     = ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, IM_I, 0);
        LUI      = ov(0, 0, 0, 1, 0, 2'b11, 2'b00, 2'b00, ADD, IM_U, 0);
        TRAP     = ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, IM_I, 1);
        Z        = '0;
    end

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic z, input logic s, input logic [2:0] n,
                                input outv_t e0, input outv_t e1, input outv_t e2,
                                input outv_t e3, input outv_t e4);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.s = s; v.n = n;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3; v.e[4] = e4;
        return v;
    endfunction

    task automatic cmp_pop(input int tag);
        outv_t want;
        n_cmp++;
        if (scb.size() == 0) begin
            n_bad++;
            $display("FAIL tag%0d scoreboard empty, got=%h", tag, act);
        end else begin
            want = scb.pop_front();
            if (act !== want) begin
                n_bad++;
                $display("FAIL tag%0d got=%h want=%h", tag, act, want);
            end
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input logic s);
        opcode = op; func3 = f3; func7 = f7; zero = z; sign = s;
    endtask

    // Compare one cycle then advance to the next falling edge.
    task automatic step(input int tag);
        #1;
        cmp_pop(tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Instruction table: opcode, func3, func7, zero, sign, cycles, per-cycle outputs.
        tbl.push_back(mk(7'b0110011, 3'b000, 7'b0100000, 0, 0, 4, f_fetch(1), f_decode(0), f_execr(SUB),  ALUWB, Z));
        tbl.push_back(mk(7'b0110011, 3'b000, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(0), f_execr(ADD),  ALUWB, Z));
        tbl.push_back(mk(7'b0110011, 3'b010, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(0), f_execr(SLT),  ALUWB, Z));
        tbl.push_back(mk(7'b0110011, 3'b011, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(0), f_execr(SLTU), ALUWB, Z));
        tbl.push_back(mk(7'b0110011, 3'b100, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(0), f_execr(XOR_), ALUWB, Z));
        tbl.push_back(mk(7'b0110011, 3'b110, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(0), f_execr(OR_),  ALUWB, Z));
        tbl.push_back(mk(7'b0110011, 3'b111, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(0), f_execr(AND_), ALUWB, Z));
        tbl.push_back(mk(7'b0110011, 3'b001, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(0), f_execr(ADD),  ALUWB, Z));
        tbl.push_back(mk(7'b0010011, 3'b000, 7'b0100000, 0, 0, 4, f_fetch(1), f_decode(0), f_execi(ADD),  ALUWB, Z));
        tbl.push_back(mk(7'b0010011, 3'b100, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(0), f_execi(XOR_), ALUWB, Z));
        tbl.push_back(mk(7'b0010011, 3'b111, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(0), f_execi(AND_), ALUWB, Z));
        tbl.push_back(mk(7'b0000011, 3'b010, 7'b0000000, 0, 0, 5, f_fetch(1), f_decode(0), f_memadr(0), MEMREAD, MEMWB));
        tbl.push_back(mk(7'b0100011, 3'b010, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(0), f_memadr(1), MEMWRITE, Z));
        tbl.push_back(mk(7'b1100011, 3'b000, 7'b0000000, 1, 0, 3, f_fetch(1), f_decode(0), f_branch(1), Z, Z));
        tbl.push_back(mk(7'b1100011, 3'b001, 7'b0000000, 1, 0, 3, f_fetch(1), f_decode(0), f_branch(0), Z, Z));
        tbl.push_back(mk(7'b1100011, 3'b100, 7'b0000000, 0, 1, 3, f_fetch(1), f_decode(0), f_branch(1), Z, Z));
        tbl.push_back(mk(7'b1100011, 3'b101, 7'b0000000, 0, 1, 3, f_fetch(1), f_decode(0), f_branch(0), Z, Z));
        tbl.push_back(mk(7'b1100011, 3'b010, 7'b0000000, 1, 1, 3, f_fetch(1), f_decode(0), f_branch(0), Z, Z));
        tbl.push_back(mk(7'b1100011, 3'b000, 7'b0000000, 0, 0, 3, f_fetch(1), f_decode(0), f_branch(0), Z, Z));
        tbl.push_back(mk(7'b1100011, 3'b001, 7'b0000000, 0, 0, 3, f_fetch(1), f_decode(0), f_branch(1), Z, Z));
        tbl.push_back(mk(7'b1100011, 3'b101, 7'b0000000, 0, 0, 3, f_fetch(1), f_decode(0), f_branch(1), Z, Z));
        tbl.push_back(mk(7'b1100011, 3'b110, 7'b0000000, 1, 1, 3, f_fetch(1), f_decode(0), f_branch(0), Z, Z));
        tbl.push_back(mk(7'b1101111, 3'b000, 7'b0000000, 0, 0, 4, f_fetch(1), f_decode(1), JAL, ALUWB, Z));
        tbl.push_back(mk(7'b1100111, 3'b000, 7'b0000000, 0, 0, 5, f_fetch(1), f_decode(0), JTGT, JAL, ALUWB));
        tbl.push_back(mk(7'b0110111, 3'b000, 7'b0000000, 0, 0, 3, f_fetch(1), f_decode(0), LUI, Z, Z));

        // Reset state: FETCH selects with every enable masked.
        @(negedge clk);
        scb.push_back(f_fetch(0));
        cmp_pop(900);
        rst = 1'b0;
        #1;
        scb.push_back(f_fetch(1));
        cmp_pop(901);

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].s);
            for (int k = 0; k < int'(tbl[i].n); k++) scb.push_back(tbl[i].e[k]);
            for (int k = 0; k < int'(tbl[i].n); k++) step(i * 10 + k);
        end

        // Reset in the middle of MEMWRITE: MemWrite must drop in the same cycle.
        drive(7'b0100011, 3'b010, 7'b0000000, 0, 0);
        scb.push_back(f_fetch(1));
        scb.push_back(f_decode(0));
        scb.push_back(f_memadr(1));
        for (int k = 0; k < 3; k++) step(910 + k);
        #1;
        scb.push_back(MEMWRITE);
        cmp_pop(913);
        #1 rst = 1'b1;
        #1;
        scb.push_back(f_fetch(0));
        cmp_pop(914);
        @(posedge clk);
        @(negedge clk);
        scb.push_back(f_fetch(0));
        cmp_pop(915);
        rst = 1'b0;
        #1;
        scb.push_back(f_fetch(1));
        cmp_pop(916);

        // Unknown opcode 0000000.
        drive(7'b0000000, 3'b000, 7'b0000000, 0, 0);
        scb.push_back(f_fetch(1));
        scb.push_back(f_decode(0));
        step(920);
        step(921);
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 10; k++) begin
            scb.push_back(TRAP);
            step(930 + k);
        end
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        scb.push_back(f_fetch(1));
        cmp_pop(940);
`else
        scb.push_back(f_fetch(1));
        step(940);
        scb.push_back(f_decode(0));
        step(941);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
